// File: rtl/cpu_pkg.sv
// Shared decode/writeback types: chain entry layout and register index width.
package cpu_pkg;

    localparam int NUM_REGS_DEF = 32;
    localparam int REG_IDX_W    = $clog2(NUM_REGS_DEF);

    typedef struct packed {
        logic [REG_IDX_W-1:0] reg_d;
        logic                 write_en;
        logic                 latent;
    } chain_entry_t;

    localparam chain_entry_t NOP_ENTRY = '0;

endpackage

// File: rtl/cpu_bypass_select.sv
// Matches one source operand against the in-flight chain (index 0 = stage 1, youngest).
module cpu_bypass_select
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
)(
    input  chain_entry_t [DEPTH-1:0] entries,
    input  logic [REG_IDX_W-1:0]     reg_idx,
    input  logic                     use_en,
    output logic [DEPTH-1:0]         sel,
    output logic                     latent_hit
);

    // Walk oldest to youngest so the youngest short writer ends up selected.
    always_comb begin
        sel        = '0;
        latent_hit = 1'b0;
        if (use_en && reg_idx != '0) begin
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (entries[k].write_en && entries[k].reg_d == reg_idx) begin
                    if (entries[k].latent) begin
                        latent_hit = 1'b1;
                    end else begin
                        sel    = '0;
                        sel[k] = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/cpu_scoreboard.sv
// Decode-stage hazard/bypass controller with a scoreboard for latent results.
// Optional: CPU_SCOREBOARD_WB_BYPASS_EN forwards the writeback port in its own cycle.
module cpu_scoreboard
    import cpu_pkg::*;
#(
    parameter int NUM_REGS        = 32,
    parameter int DEPTH           = 2,
    parameter int MAX_OUTSTANDING = 4
)(
    input  logic                                 clock,
    input  logic                                 reset_n,
    input  logic                                 stall,
    input  logic                                 flush,
    input  logic                                 p2_valid,
    input  logic [$clog2(NUM_REGS)-1:0]          p2_reg_a,
    input  logic [$clog2(NUM_REGS)-1:0]          p2_reg_b,
    input  logic [$clog2(NUM_REGS)-1:0]          p2_reg_d,
    input  logic                                 p2_use_a,
    input  logic                                 p2_use_b,
    input  logic                                 p2_write_en,
    input  logic                                 p2_latent,
    input  logic                                 wb_valid,
    input  logic [$clog2(NUM_REGS)-1:0]          wb_reg_d,
    output logic                                 p2_bubble,
    output logic [DEPTH-1:0]                     p2_bypass_a,
    output logic [DEPTH-1:0]                     p2_bypass_b,
    output logic                                 p2_bypass_wb_a,
    output logic                                 p2_bypass_wb_b,
    output logic [$clog2(NUM_REGS)-1:0]          commit_reg_d,
    output logic                                 commit_write_en,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding
);

    localparam int RIDX_W = $clog2(NUM_REGS);
    localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);

    chain_entry_t [DEPTH-1:0] chain_q;
    chain_entry_t             issue_entry;
    logic [NUM_REGS-1:0]      sb_q;
    logic [NUM_REGS-1:0]      sb_d;
    logic [OUT_W-1:0]         out_q;

    logic              eff_we;
    logic [DEPTH-1:0]  byp_a, byp_b;
    logic              lat_a, lat_b;
    logic              wb_hit_a, wb_hit_b;
    logic              raw_sb_a, raw_sb_b;
    logic              waw_chain, waw, cap_full, hazard;
    int unsigned       lat_cnt;
    logic              sb_set, sb_clr;
    logic [RIDX_W-1:0] set_idx;

    assign eff_we = p2_valid & p2_write_en & (p2_reg_d != '0);

    cpu_bypass_select #(.DEPTH(DEPTH)) u_sel_a (
        .entries    (chain_q),
        .reg_idx    (REG_IDX_W'(p2_reg_a)),
        .use_en     (p2_use_a),
        .sel        (byp_a),
        .latent_hit (lat_a)
    );

    cpu_bypass_select #(.DEPTH(DEPTH)) u_sel_b (
        .entries    (chain_q),
        .reg_idx    (REG_IDX_W'(p2_reg_b)),
        .use_en     (p2_use_b),
        .sel        (byp_b),
        .latent_hit (lat_b)
    );

`ifdef CPU_SCOREBOARD_WB_BYPASS_EN
    assign wb_hit_a = wb_valid & p2_use_a & (p2_reg_a != '0) & (wb_reg_d == p2_reg_a);
    assign wb_hit_b = wb_valid & p2_use_b & (p2_reg_b != '0) & (wb_reg_d == p2_reg_b);
`else
    assign wb_hit_a = 1'b0;
    assign wb_hit_b = 1'b0;
`endif

    // A chain-stage match is younger than the writeback result, so it wins.
    assign p2_bypass_a    = byp_a;
    assign p2_bypass_b    = byp_b;
    assign p2_bypass_wb_a = wb_hit_a & ~|byp_a;
    assign p2_bypass_wb_b = wb_hit_b & ~|byp_b;

    assign raw_sb_a = p2_use_a & (p2_reg_a != '0) & sb_q[p2_reg_a] & ~wb_hit_a;
    assign raw_sb_b = p2_use_b & (p2_reg_b != '0) & sb_q[p2_reg_b] & ~wb_hit_b;

    always_comb begin
        waw_chain = 1'b0;
        lat_cnt   = 0;
        for (int k = 0; k < DEPTH; k++) begin
            if (chain_q[k].write_en && chain_q[k].latent) begin
                lat_cnt = lat_cnt + 1;
                if (chain_q[k].reg_d == REG_IDX_W'(p2_reg_d)) waw_chain = 1'b1;
            end
        end
    end

    // Latent ops still in the chain will claim a slot once they commit.
    assign cap_full  = (32'(out_q) + lat_cnt) >= 32'(MAX_OUTSTANDING);
    assign waw       = eff_we & p2_latent & (sb_q[p2_reg_d] | waw_chain);
    assign hazard    = lat_a | lat_b | raw_sb_a | raw_sb_b | waw | (p2_latent & cap_full);
    assign p2_bubble = p2_valid & ~flush & hazard;

    always_comb begin
        issue_entry = NOP_ENTRY;
        if (p2_valid && !flush && !hazard) begin
            issue_entry.reg_d    = REG_IDX_W'(p2_reg_d);
            issue_entry.write_en = eff_we;
            issue_entry.latent   = p2_latent;
        end
    end

    assign set_idx         = RIDX_W'(chain_q[DEPTH-1].reg_d);
    assign commit_reg_d    = set_idx;
    assign commit_write_en = chain_q[DEPTH-1].write_en & ~chain_q[DEPTH-1].latent;
    assign outstanding     = out_q;

    // Writeback clears are accepted even while the chain is stalled.
    assign sb_set = ~stall & chain_q[DEPTH-1].write_en & chain_q[DEPTH-1].latent;
    assign sb_clr = wb_valid & (wb_reg_d != '0) & sb_q[wb_reg_d];

    always_comb begin
        sb_d = sb_q;
        if (sb_clr) sb_d[wb_reg_d] = 1'b0;
        if (sb_set) sb_d[set_idx]  = 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            chain_q <= '0;
            sb_q    <= '0;
            out_q   <= '0;
        end else begin
            sb_q <= sb_d;
            if (sb_set && !sb_clr) begin
                out_q <= out_q + OUT_W'(1);
            end else if (sb_clr && !sb_set) begin
                out_q <= out_q - OUT_W'(1);
            end
            if (!stall) begin
                chain_q[0] <= issue_entry;
                for (int k = 1; k < DEPTH; k++) begin
                    chain_q[k] <= flush ? NOP_ENTRY : chain_q[k-1];
                end
            end
        end
    end

    a_wb_busy : assert property (@(posedge clock) disable iff (!reset_n)
        (wb_valid && wb_reg_d != '0) |-> sb_q[wb_reg_d]);

endmodule
